ssc_rx_buffer: RTL

Receive-side line buffer between the framework serial pin and the Super Serial Card's receive input. It deserializes 8N1 bytes arriving from the host and holds them in a FIFO. It re-serializes them toward the card only while the card's 6551 asserts RTS, so no characters are lost while Apple II firmware is busy. It also drives hardware flow control back to the host, and reports overrun and framing errors.

---
 rtl/ssc_rx_buffer.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ssc_rx_buffer.sv
// ssc_rx_buffer: 8N1 receive line buffer between the framework serial pin and the SSC receive input.
// Optional macro SSC_RXBUF_FLOWCTL_EN gates draining on the card's RTS and drives HOST_CTS_N.

module ssc_rx_buffer #(
   parameter int BAUD_DIV   = 1491,
   parameter int DEPTH_LOG2 = 4,
   parameter int HEADROOM   = 4
) (
   input  logic                  CLK_14M,
   input  logic                  RESET,
   input  logic                  HOST_RXD,
   output logic                  HOST_CTS_N,
   output logic                  CARD_RXD,
   input  logic                  CARD_RTS_N,
   input  logic                  CLR_ERR,
   output logic [DEPTH_LOG2:0]   FIFO_COUNT,
   output logic                  OVERRUN,
   output logic                  FRAME_ERR
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   localparam logic [11:0]           BIT_LAST  = 12'(BAUD_DIV - 1);
   localparam logic [11:0]           HALF_LAST = 12'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } ser_state_t;

   // Internal handshake: rx_push_q is a one-cycle strobe with its byte on rx_data_q; the FIFO
   // cannot stall it, so a strobe while full with no pop is an overrun. fifo_pop is raised only
   // when the FIFO holds data, and fifo_dout is valid in that same cycle.

   // ------------------------------------------------------------------
   // Host line synchronizer and falling-edge detect
   // ------------------------------------------------------------------
   logic rxd_s1, rxd_s2, rxd_s3;
   logic rx_fall;

   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
         rxd_s3 <= 1'b1;
      end else begin
         rxd_s1 <= HOST_RXD;
         rxd_s2 <= rxd_s1;
         rxd_s3 <= rxd_s2;
      end
   end

   assign rx_fall = rxd_s3 & ~rxd_s2;

   // ------------------------------------------------------------------
   // RX FSM
   // ------------------------------------------------------------------
   ser_state_t  rx_state, rx_next;
   logic [11:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_half_done, rx_bit_done;
   logic        rx_sample, rx_push_d, rx_ferr_d;
   logic        rx_push_q;
   logic [7:0]  rx_data_q;

   assign rx_half_done = (rx_cnt == HALF_LAST);
   assign rx_bit_done  = (rx_cnt == BIT_LAST);

   always_ff @(posedge CLK_14M) begin
      if (RESET) rx_state <= S_IDLE;
      else       rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_fall) rx_next = S_START;
         S_START: if (rx_half_done) rx_next = rxd_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (rx_bit_done && (rx_bit == 3'd7)) rx_next = S_STOP;
         S_STOP:  if (rx_bit_done) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_sample = 1'b0;
      rx_push_d = 1'b0;
      rx_ferr_d = 1'b0;
      case (rx_state)
         S_DATA:  rx_sample = rx_bit_done;
         S_STOP: begin
            rx_push_d = rx_bit_done & rxd_s2;
            rx_ferr_d = rx_bit_done & ~rxd_s2;
         end
         default: ;
      endcase
   end

   // Counter restarts on every state change and after every data sample.
   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_push_q <= 1'b0;
         rx_data_q <= '0;
      end else begin
         if ((rx_state == S_IDLE) || (rx_next != rx_state) || rx_sample)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 12'd1;

         if (rx_state != S_DATA)
            rx_bit <= '0;
         else if (rx_sample)
            rx_bit <= rx_bit + 3'd1;

         if (rx_sample)
            rx_shift <= {rxd_s2, rx_shift[7:1]};

         rx_push_q <= rx_push_d;
         if (rx_push_d)
            rx_data_q <= rx_shift;
      end
   end

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  fifo_full, fifo_empty, do_push, fifo_pop;
   logic [7:0]            fifo_dout;

   assign fifo_full  = (count == CNT_FULL);
   assign fifo_empty = (count == '0);
   assign do_push    = rx_push_q & (~fifo_full | fifo_pop);
   assign fifo_dout  = mem[rd_ptr];

   always_ff @(posedge CLK_14M) begin
      if (do_push)
         mem[wr_ptr] <= rx_data_q;
   end

   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)  wr_ptr <= wr_ptr + PTR_ONE;
         if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, fifo_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Card-side ready
   // ------------------------------------------------------------------
   logic rts_ok;

`ifdef SSC_RXBUF_FLOWCTL_EN
   logic rts_s1, rts_s2;

   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         rts_s1 <= 1'b1;
         rts_s2 <= 1'b1;
      end else begin
         rts_s1 <= CARD_RTS_N;
         rts_s2 <= rts_s1;
      end
   end

   assign rts_ok = ~rts_s2;
`else
   logic unused_rts;
   assign unused_rts = CARD_RTS_N;
   assign rts_ok     = 1'b1;
`endif

   // ------------------------------------------------------------------
   // TX FSM
   // ------------------------------------------------------------------
   ser_state_t  tx_state, tx_next;
   logic [11:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_bit_done, tx_load;
   logic        card_q;

   assign tx_bit_done = (tx_cnt == BIT_LAST);

   always_ff @(posedge CLK_14M) begin
      if (RESET) tx_state <= S_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:  if (fifo_pop) tx_next = S_START;
         S_START: if (tx_bit_done) tx_next = S_DATA;
         S_DATA:  if (tx_bit_done && (tx_bit == 3'd7)) tx_next = S_STOP;
         S_STOP:  if (tx_bit_done) tx_next = fifo_pop ? S_START : S_IDLE;
         default: tx_next = S_IDLE;
      endcase
   end

   // The final stop-bit cycle counts as idle so back-to-back frames abut with no gap.
   always_comb begin
      tx_load  = (tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_bit_done);
      fifo_pop = tx_load & ~fifo_empty & rts_ok;
   end

   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         card_q   <= 1'b1;
      end else begin
         if ((tx_state == S_IDLE) || tx_bit_done)
            tx_cnt <= '0;
         else
            tx_cnt <= tx_cnt + 12'd1;

         if (tx_state != S_DATA)
            tx_bit <= '0;
         else if (tx_bit_done)
            tx_bit <= tx_bit + 3'd1;

         if (fifo_pop)
            tx_shift <= fifo_dout;
         else if ((tx_state == S_DATA) && tx_bit_done)
            tx_shift <= {1'b1, tx_shift[7:1]};

         if (fifo_pop)
            card_q <= 1'b0;
         else if ((tx_state == S_START) && tx_bit_done)
            card_q <= tx_shift[0];
         else if ((tx_state == S_DATA) && tx_bit_done)
            card_q <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
         else if ((tx_state == S_STOP) && tx_bit_done)
            card_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Host flow control
   // ------------------------------------------------------------------
`ifdef SSC_RXBUF_FLOWCTL_EN
   logic cts_q;

   always_ff @(posedge CLK_14M) begin
      if (RESET)
         cts_q <= 1'b0;
      else if (count >= CW'(DEPTH - HEADROOM))
         cts_q <= 1'b1;
      else if (count <= CW'(DEPTH / 2))
         cts_q <= 1'b0;
   end

   assign HOST_CTS_N = cts_q;
`else
   localparam int unused_headroom = HEADROOM;
   assign HOST_CTS_N = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Sticky error flags: a new set condition beats a simultaneous clear
   // ------------------------------------------------------------------
   logic overrun_q, frame_err_q;

   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (rx_push_q && fifo_full && !fifo_pop)
            overrun_q <= 1'b1;
         else if (CLR_ERR)
            overrun_q <= 1'b0;

         if (rx_ferr_d)
            frame_err_q <= 1'b1;
         else if (CLR_ERR)
            frame_err_q <= 1'b0;
      end
   end

   assign CARD_RXD   = card_q;
   assign FIFO_COUNT = count;
   assign OVERRUN    = overrun_q;
   assign FRAME_ERR  = frame_err_q;

endmodule
